hsv_core_mem_access_seq: RTL

//  Load/store access sequencer between decoded memory ops and the data bus.
//  - Takes one access per handshake (addr, size, direction, sign_extend, store data).
//  - Turns it into 1 or 2 bus-width aligned beats with byte strobes.
//  - Merges and extends load data, then returns one result per access.
//  - Generalises the fixed 32-bit byte/half/word handling to XLEN 32/64 with dword and split accesses.

---
 rtl/hsv_core_mem_access_seq_if.sv | 24 ++
 rtl/hsv_core_mem_access_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/hsv_core_mem_access_seq_if.sv
// hsv_core_mem_access_seq_if: request, data-bus and result channels of the memory access sequencer
interface hsv_core_mem_access_seq_if #(parameter int XLEN = 32);
  localparam int BB = XLEN / 8;
  logic in_valid, in_ready, in_write, in_sign_extend;
  logic [XLEN-1:0] in_addr, in_wdata;
  logic [1:0] in_size;
  logic bus_valid, bus_ready, bus_write, bus_rsp_valid;
  logic [XLEN-1:0] bus_addr, bus_wdata, bus_rsp_rdata;
  logic [BB-1:0] bus_strb;
  logic out_valid, out_ready, out_fault;
  logic [XLEN-1:0] out_rdata;
  modport slave (
    input in_valid, in_addr, in_size, in_write, in_sign_extend, in_wdata,
    input bus_ready, bus_rsp_valid, bus_rsp_rdata, out_ready,
    output in_ready, bus_valid, bus_addr, bus_write, bus_strb, bus_wdata,
    output out_valid, out_rdata, out_fault
  );
  modport master (
    output in_valid, in_addr, in_size, in_write, in_sign_extend, in_wdata,
    output bus_ready, bus_rsp_valid, bus_rsp_rdata, out_ready,
    input in_ready, bus_valid, bus_addr, bus_write, bus_strb, bus_wdata,
    input out_valid, out_rdata, out_fault
  );
endinterface

// File: rtl/hsv_core_mem_access_seq.sv
// hsv_core_mem_access_seq: load/store sequencer issuing aligned bus beats; HSV_CORE_MEM_SPLIT_EN enables two-beat bus-crossing accesses
module hsv_core_mem_access_seq #(parameter int XLEN = 32) (
  input logic clk_core,
  input logic rst_core,
  input logic flush,
  hsv_core_mem_access_seq_if.slave io
);
  localparam int BUS_BYTES = XLEN / 8;
  localparam int OW = $clog2(BUS_BYTES);
`ifdef HSV_CORE_MEM_SPLIT_EN
  localparam int NBEAT = 2;
  typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, DONE, FAULT} state_t;
`else
  localparam int NBEAT = 1;
  typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, DONE, FAULT} state_t;
`endif
  localparam int NW = NBEAT * XLEN;
  localparam int NS = NBEAT * BUS_BYTES;
  state_t state, state_n;
  logic [XLEN-1:0] addr_q, res_q;
  logic [OW-1:0] off, off_q;
  logic [1:0] size_q;
  logic write_q, sext_q, bad;
  logic [3:0] nb;
  logic [NS-1:0] strb_n, strb_q;
  logic [NW-1:0] wdata_n, wdata_q;
`ifdef HSV_CORE_MEM_SPLIT_EN
  logic split_n, split_q;
  logic [XLEN-1:0] lo_q;
`endif
  // Shift the raw beat window down to the access, then extend via shift-up / shift-down
  function automatic logic [XLEN-1:0] merge(input logic [NW-1:0] raw, input logic [OW-1:0] o,
                                            input logic [1:0] sz, input logic sx);
    logic [NW-1:0] s;
    logic [XLEN-1:0] t;
    logic signed [XLEN-1:0] a;
    logic [6:0] sh;
    s = raw >> {o, 3'b000};
    sh = 7'(XLEN) - (7'd8 << sz);
    t = s[XLEN-1:0] << sh;
    a = $signed(t) >>> sh;
    return sx ? a : t >> sh;
  endfunction
  always_comb begin
    off = io.in_addr[OW-1:0];
    nb = 4'd1 << io.in_size;
    strb_n = ((NS'(1) << nb) - NS'(1)) << off;
    wdata_n = NW'(io.in_wdata) << {off, 3'b000};
`ifdef HSV_CORE_MEM_SPLIT_EN
    split_n = 5'(off) + 5'(nb) > 5'(BUS_BYTES);
    bad = io.in_size == 2'd3 && XLEN == 32;
`else
    bad = (io.in_size == 2'd3 && XLEN == 32) || |(io.in_addr[2:0] & 3'(nb - 4'd1));
`endif
    state_n = state;
    case (state)
      IDLE: state_n = io.in_valid ? (bad ? FAULT : BEAT0) : IDLE;
      BEAT0: state_n = io.bus_ready ? WAIT0 : BEAT0;
`ifdef HSV_CORE_MEM_SPLIT_EN
      WAIT0: state_n = io.bus_rsp_valid ? (split_q ? BEAT1 : DONE) : WAIT0;
      BEAT1: state_n = io.bus_ready ? WAIT1 : BEAT1;
      WAIT1: state_n = io.bus_rsp_valid ? DONE : WAIT1;
`else
      WAIT0: state_n = io.bus_rsp_valid ? DONE : WAIT0;
`endif
      DONE, FAULT: state_n = io.out_ready ? IDLE : state;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_core) begin
    if (rst_core || flush) begin
      state <= IDLE;
      write_q <= 1'b0;
      res_q <= '0;
    end else begin
      state <= state_n;
      if (io.in_valid && state == IDLE) begin
        addr_q <= {io.in_addr[XLEN-1:OW], OW'(0)};
        off_q <= off;
        size_q <= io.in_size;
        write_q <= io.in_write;
        sext_q <= io.in_sign_extend;
        strb_q <= strb_n;
        wdata_q <= wdata_n;
`ifdef HSV_CORE_MEM_SPLIT_EN
        split_q <= split_n;
`endif
      end
      if (state == WAIT0 && io.bus_rsp_valid)
        res_q <= write_q ? '0 : merge(NW'(io.bus_rsp_rdata), off_q, size_q, sext_q);
`ifdef HSV_CORE_MEM_SPLIT_EN
      if (state == WAIT0 && io.bus_rsp_valid)
        lo_q <= io.bus_rsp_rdata;
      if (state == WAIT1 && io.bus_rsp_valid)
        res_q <= write_q ? '0 : merge({io.bus_rsp_rdata, lo_q}, off_q, size_q, sext_q);
`endif
    end
  end
`ifdef HSV_CORE_MEM_SPLIT_EN
  logic hi;
  assign hi = state == BEAT1;
  assign io.bus_valid = state == BEAT0 || hi;
  assign io.bus_addr = hi ? addr_q + XLEN'(BUS_BYTES) : addr_q;
  assign io.bus_strb = hi ? strb_q[NS-1:BUS_BYTES] : state == BEAT0 ? strb_q[BUS_BYTES-1:0] : '0;
  assign io.bus_wdata = hi ? wdata_q[NW-1:XLEN] : wdata_q[XLEN-1:0];
`else
  assign io.bus_valid = state == BEAT0;
  assign io.bus_addr = addr_q;
  assign io.bus_strb = state == BEAT0 ? strb_q : '0;
  assign io.bus_wdata = wdata_q;
`endif
  assign io.in_ready = state == IDLE;
  assign io.bus_write = write_q;
  assign io.out_valid = state == DONE || state == FAULT;
  assign io.out_fault = state == FAULT;
  assign io.out_rdata = state == DONE ? res_q : '0;
endmodule
